picorv_loader_ctrl: RTL

System-clock-side sequencer for the PicoRV32 subsystem. It drains the USB-written state FIFO and memory FIFO. It writes program bytes little-endian into core memory and holds or releases the core's reset according to the commanded state. It also arbitrates the shared serial FIFO: the loader's byte-count reports own it in LOAD, and the running core's serial output owns it in RUN.

---
 rtl/picorv_loader_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/picorv_loader_ctrl.sv
// rtl/picorv_loader_ctrl.sv - PicoRV32 loader sequencer: state/memory FIFO drain, core memory writes, serial arbitration
//
// Purpose: pops the USB-written state and memory FIFOs (one read outstanding,
// state FIFO first), writes program bytes little-endian into core memory while
// in LOAD, drives the core reset from the commanded state and arbitrates the
// shared serial FIFO between byte-count reports (LOAD) and core output (RUN).
//
// Ports:
//   i_clk, i_resetn                     clock, async active-low reset
//   i_state_fifo_* / o_state_fifo_rd_en state command FIFO read side
//   i_mem_fifo_*   / o_mem_fifo_rd_en   program byte FIFO read side
//   o_mem_wr_*                          core memory byte write port
//   o_core_resetn                       PicoRV32 reset, active-low
//   i_core_ser_* / o_core_ser_ready     core serial word handshake
//   i_serial_fifo_full, o_serial_fifo_* shared serial FIFO write side
//   o_loader_state                      one-hot 001 RUN, 010 LOAD, 100 RESET
//   o_load_overflow                     sticky: byte received past MEM_BYTES
module picorv_loader_ctrl #(
  parameter int MEM_BYTES = 16384,
  parameter int ADDR_W    = 12
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_state_fifo_empty,
  input  logic [7:0]        i_state_fifo_out,
  output logic              o_state_fifo_rd_en,
  input  logic              i_mem_fifo_empty,
  input  logic [7:0]        i_mem_fifo_out,
  output logic              o_mem_fifo_rd_en,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_wr_addr,
  output logic [31:0]       o_mem_wr_data,
  output logic [3:0]        o_mem_wr_strb,
  output logic              o_core_resetn,
  input  logic              i_core_ser_valid,
  input  logic [31:0]       i_core_ser_data,
  output logic              o_core_ser_ready,
  input  logic              i_serial_fifo_full,
  output logic              o_serial_fifo_wr_en,
  output logic [31:0]       o_serial_fifo_in,
  output logic [2:0]        o_loader_state,
  output logic              o_load_overflow
);

  localparam int               CNT_W   = ADDR_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_BYTES);

  typedef enum logic [2:0] {
    ST_RUN   = 3'b001,
    ST_LOAD  = 3'b010,
    ST_RESET = 3'b100
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_cap_state, r_cap_mem;
  logic [CNT_W-1:0]   r_byte_count, w_count_nxt;
  logic               r_overflow, w_ovf_nxt;
  logic               r_report_pending, w_pend_nxt;
  logic               r_core_resetn;
  logic               r_mem_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]  r_mem_wr_addr, w_wr_addr_nxt;
  logic [31:0]        r_mem_wr_data, w_wr_data_nxt;
  logic [3:0]         r_mem_wr_strb, w_wr_strb_nxt;

  logic               w_busy, w_st_fetch, w_mem_fetch;
  logic               w_report, w_ser_acc;
  logic               w_unused;

  // Only the low three bits of a state command carry meaning.
  assign w_unused = &{1'b0, i_state_fifo_out[7:3]};

  always_comb begin
    // A pending capture blocks the next fetch: one read in flight at a time.
    w_busy      = r_cap_state | r_cap_mem;
    w_st_fetch  = ~w_busy & ~i_state_fifo_empty;
    w_mem_fetch = ~w_busy & i_state_fifo_empty & ~i_mem_fifo_empty & (r_state == ST_LOAD);

    w_report  = (r_state == ST_LOAD) & r_report_pending & ~i_serial_fifo_full;
    w_ser_acc = (r_state == ST_RUN) & i_core_ser_valid & ~i_serial_fifo_full;

    // Pops are masked while reset is held so the FIFOs are never drained
    // by a controller that cannot capture the data.
    o_state_fifo_rd_en  = i_resetn & w_st_fetch;
    o_mem_fifo_rd_en    = i_resetn & w_mem_fetch;
    o_core_ser_ready    = w_ser_acc;
    o_serial_fifo_wr_en = w_report | w_ser_acc;
    o_serial_fifo_in    = 32'd0;
    if (w_ser_acc) begin
      o_serial_fifo_in = i_core_ser_data;
    end else if (w_report) begin
      o_serial_fifo_in = 32'(r_byte_count);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_byte_count;
    w_ovf_nxt     = r_overflow;
    w_pend_nxt    = r_report_pending & ~w_report;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_mem_wr_addr;
    w_wr_data_nxt = r_mem_wr_data;
    w_wr_strb_nxt = r_mem_wr_strb;

    if (r_cap_state) begin
      // Any command either re-enters LOAD or leaves it; a stale report
      // is dropped in both cases.
      w_pend_nxt = 1'b0;
      case (i_state_fifo_out[2:0])
        3'b001: w_state_nxt = ST_RUN;
        3'b010: begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
        default: begin
          w_state_nxt = ST_RESET;
          w_count_nxt = '0;
        end
      endcase
    end else if (r_cap_mem) begin
      if (r_byte_count == CNT_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_byte_count[ADDR_W+1:2];
        w_wr_data_nxt = {4{i_mem_fifo_out}};
        w_wr_strb_nxt = 4'b0001 << r_byte_count[1:0];
        w_count_nxt   = r_byte_count + CNT_W'(1);
        // A new capture outranks a report leaving this same cycle, so the
        // latest count is always reported.
        w_pend_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state          <= ST_RESET;
      r_cap_state      <= 1'b0;
      r_cap_mem        <= 1'b0;
      r_byte_count     <= '0;
      r_overflow       <= 1'b0;
      r_report_pending <= 1'b0;
      r_core_resetn    <= 1'b0;
      r_mem_wr_en      <= 1'b0;
      r_mem_wr_addr    <= '0;
      r_mem_wr_data    <= '0;
      r_mem_wr_strb    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_cap_state      <= w_st_fetch;
      r_cap_mem        <= w_mem_fetch;
      r_byte_count     <= w_count_nxt;
      r_overflow       <= w_ovf_nxt;
      r_report_pending <= w_pend_nxt;
      // Follows the visible state by one cycle in both directions.
      r_core_resetn    <= (r_state == ST_RUN);
      r_mem_wr_en      <= w_wr_en_nxt;
      r_mem_wr_addr    <= w_wr_addr_nxt;
      r_mem_wr_data    <= w_wr_data_nxt;
      r_mem_wr_strb    <= w_wr_strb_nxt;
    end
  end

  assign o_mem_wr_en     = r_mem_wr_en;
  assign o_mem_wr_addr   = r_mem_wr_addr;
  assign o_mem_wr_data   = r_mem_wr_data;
  assign o_mem_wr_strb   = r_mem_wr_strb;
  assign o_core_resetn   = r_core_resetn;
  assign o_loader_state  = r_state;
  assign o_load_overflow = r_overflow;

endmodule
